// File: rtl/ybus_if.sv
// ybus_if: four-phase YBUS sender/receiver link
// Signals: YREQ/YDATA/YPARITY from sender; YACK/PARITYSEL back from receiver.
// Modports: master = sender side, slave = receiver side.
interface ybus_if;
  logic        YREQ;
  logic [31:0] YDATA;
  logic        YPARITY;
  logic        YACK;
  logic        PARITYSEL;
  modport master (output YREQ, YDATA, YPARITY, input YACK, PARITYSEL);
  modport slave  (input YREQ, YDATA, YPARITY, output YACK, PARITYSEL);
endinterface

// File: rtl/ybus_receiver.sv
// ybus_receiver: four-phase YBUS receiver with parity check and DEPTH-entry receive FIFO
// Ports: clk, rst (sync, active-high); y (ybus_if.slave: YREQ/YDATA/YPARITY in, YACK/PARITYSEL out);
//        cfg_odd (requested parity mode); rd_valid/rd_data/rd_pop (FIFO read side);
//        parity_err (one-cycle reject pulse); err_count (saturating reject count).
module ybus_receiver #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  ybus_if.slave       y,
  input  logic        cfg_odd,
  output logic        rd_valid,
  output logic [31:0] rd_data,
  input  logic        rd_pop,
  output logic        parity_err,
  output logic [7:0]  err_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  typedef enum logic {IDLE, ACK} state_t;
  state_t state, state_nxt;
  logic [31:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic psel, capture, pass, push, pop;
  always_ff @(posedge clk) state <= rst ? IDLE : state_nxt;
  always_comb state_nxt = (state == IDLE) ? (capture ? ACK : IDLE) : (y.YREQ ? ACK : IDLE);
  // Full check uses the registered count, so a same-edge pop never frees room for a capture.
  always_comb begin
    capture = (state == IDLE) && y.YREQ && (count < CW'(DEPTH));
    pass    = ((^y.YDATA) ^ y.YPARITY) == psel;
    push    = capture && pass;
    pop     = rd_pop && (count != '0);
  end
  assign y.YACK      = (state == ACK);
  assign y.PARITYSEL = psel;
  assign rd_valid    = (count != '0);
  assign rd_data     = mem[rd_ptr];
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= y.YDATA;
  // Parity mode is only re-sampled between transfers so the sender sees a stable mode.
  always_ff @(posedge clk) begin
    if (rst) begin
      psel       <= cfg_odd;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      parity_err <= 1'b0;
      err_count  <= '0;
    end else begin
      if (state == IDLE && !y.YREQ) psel <= cfg_odd;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count      <= count + CW'(push) - CW'(pop);
      parity_err <= capture && !pass;
      if (capture && !pass && err_count != 8'hFF) err_count <= err_count + 8'd1;
    end
  end
endmodule

// File: tb/tb_ybus_receiver.sv
// tb_ybus_receiver: randomized and directed checks of ybus_receiver against a queue-based model
module tb_ybus_receiver;
  localparam int DEPTH = 4;
  logic clk = 0, rst = 1, cfg_odd = 0, rd_pop = 0;
  logic rd_valid, parity_err;
  logic [31:0] rd_data;
  logic [7:0] err_count;
  ybus_if y();
  ybus_receiver #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .y(y), .cfg_odd(cfg_odd), .rd_valid(rd_valid),
    .rd_data(rd_data), .rd_pop(rd_pop), .parity_err(parity_err), .err_count(err_count)
  );
  always #5 clk = ~clk;
  int n_tests = 0, n_fail = 0, pulses = 0;
  bit chk_en = 0, rnd_pop = 0;
  logic m_ack, m_psel, m_perr;
  int m_errc;
  logic [31:0] m_q[$];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // Model: FIFO as a queue, transfer state as a single "acknowledging" flag.
  initial forever begin
    logic cap, pass;
    @(posedge clk);
    if (rst) begin
      m_ack = 0; m_q.delete(); m_perr = 0; m_errc = 0; m_psel = cfg_odd;
    end else begin
      cap  = !m_ack && y.YREQ && m_q.size() < DEPTH;
      pass = ((^y.YDATA) ^ y.YPARITY) == m_psel;
      if (!m_ack && !y.YREQ) m_psel = cfg_odd;
      m_perr = cap && !pass;
      if (m_perr && m_errc < 255) m_errc++;
      if (rd_pop && m_q.size() > 0) void'(m_q.pop_front());
      if (cap && pass) m_q.push_back(y.YDATA);
      m_ack = m_ack ? y.YREQ : cap;
    end
  end
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("yack", y.YACK, m_ack);
      chk("paritysel", y.PARITYSEL, m_psel);
      chk("rd_valid", rd_valid, m_q.size() != 0);
      if (m_q.size() != 0) chk("rd_data", rd_data, m_q[0]);
      chk("parity_err", parity_err, m_perr);
      chk("err_count", err_count, m_errc);
      if (parity_err) pulses++;
    end
  end
  initial forever begin
    @(negedge clk);
    if (rnd_pop) rd_pop = ($urandom_range(0, 2) == 0);
  end
  task automatic do_reset();
    @(negedge clk); rst = 1;
    @(negedge clk); rst = 0;
  endtask
  task automatic send(input logic [31:0] w, input logic p, input int hold);
    int k;
    @(negedge clk); y.YREQ = 1; y.YDATA = w; y.YPARITY = p;
    k = 0;
    do begin @(negedge clk); k++; end while (!y.YACK && k < 60);
    if (!y.YACK) begin n_tests++; n_fail++; $display("FAIL ack_timeout: YACK 0 required 1"); end
    repeat (hold) @(negedge clk);
    y.YREQ = 0; y.YDATA = $urandom; y.YPARITY = 1'($urandom);
    k = 0;
    do begin @(negedge clk); k++; end while (y.YACK && k < 60);
    if (y.YACK) begin n_tests++; n_fail++; $display("FAIL release_timeout: YACK 1 required 0"); end
  endtask
  function automatic logic good(input logic [31:0] w, input logic odd);
    return (^w) ^ odd;
  endfunction
  initial begin
    int p0;
    y.YREQ = 0; y.YDATA = 0; y.YPARITY = 0;
    repeat (2) @(negedge clk);
    rst = 0; chk_en = 1;
    chk("reset_yack", y.YACK, 0);
    chk("reset_valid", rd_valid, 0);
    chk("reset_errc", err_count, 0);
    @(negedge clk); y.YREQ = 1; y.YDATA = 32'h3; y.YPARITY = 0;
    @(negedge clk); chk("ack_latency", y.YACK, 1);
    y.YREQ = 0;
    @(negedge clk); chk("ack_drop", y.YACK, 0);
    chk("first_valid", rd_valid, 1);
    chk("first_data", rd_data, 32'h3);
    cfg_odd = 1; do_reset();
    chk("psel_odd", y.PARITYSEL, 1);
    p0 = pulses;
    send(32'h1, 1, 0);
    chk("bad_pulses", pulses - p0, 1);
    chk("bad_errc", err_count, 1);
    chk("bad_valid", rd_valid, 0);
    cfg_odd = 0; do_reset();
    for (int i = 1; i <= 4; i++) send(i, good(i, 0), 0);
    @(negedge clk); y.YREQ = 1; y.YDATA = 5; y.YPARITY = good(5, 0);
    repeat (5) @(negedge clk);
    chk("full_backpressure", y.YACK, 0);
    chk("full_head", rd_data, 1);
    rd_pop = 1;
    @(negedge clk); rd_pop = 0;
    @(negedge clk); chk("full_release_ack", y.YACK, 1);
    y.YREQ = 0;
    repeat (2) @(negedge clk);
    for (int i = 2; i <= 5; i++) begin
      chk("order", rd_data, i);
      rd_pop = 1; @(negedge clk); rd_pop = 0;
    end
    chk("drained", rd_valid, 0);
    do_reset();
    send(32'h10, good(32'h10, 0), 0);
    send(32'h11, good(32'h11, 0), 1);
    @(negedge clk); y.YREQ = 1; y.YDATA = 32'h12; y.YPARITY = good(32'h12, 0); rd_pop = 1;
    @(negedge clk); rd_pop = 0; chk("pushpop_ack", y.YACK, 1);
    y.YREQ = 0;
    repeat (2) @(negedge clk);
    chk("pushpop_head", rd_data, 32'h11);
    rd_pop = 1; @(negedge clk); rd_pop = 0;
    chk("pushpop_next", rd_data, 32'h12);
    rd_pop = 1; @(negedge clk);
    @(negedge clk);
    @(negedge clk); rd_pop = 0;
    chk("empty_pop", rd_valid, 0);
    send(32'h13, good(32'h13, 0), 0);
    chk("after_empty_pop", rd_data, 32'h13);
    rd_pop = 1; @(negedge clk); rd_pop = 0;
    chk("no_underflow", rd_valid, 0);
    p0 = pulses;
    for (int i = 0; i < 300; i++) begin
      logic [31:0] w;
      w = $urandom;
      send(w, ~good(w, 0), 0);
    end
    chk("sat_pulses", pulses - p0, 300);
    chk("sat_errc", err_count, 255);
    for (int i = 0; i < 3; i++) send(32'h40 + i, good(32'h40 + i, 0), 0);
    @(negedge clk); y.YREQ = 1; y.YDATA = 32'h44; y.YPARITY = good(32'h44, 0);
    @(negedge clk); chk("mid_ack", y.YACK, 1);
    rst = 1;
    @(negedge clk); rst = 0;
    chk("rst_yack", y.YACK, 0);
    chk("rst_valid", rd_valid, 0);
    chk("rst_errc", err_count, 0);
    @(negedge clk); chk("rst_recapture", y.YACK, 1);
    y.YREQ = 0;
    repeat (2) @(negedge clk);
    chk("rst_recapture_data", rd_data, 32'h44);
    do_reset();
    rnd_pop = 1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) cfg_odd = 1'($urandom);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send($urandom, 1'($urandom), $urandom_range(0, 3));
    end
    rnd_pop = 0;
    @(negedge clk); rd_pop = 0;
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
